// File: rtl/display_scan_ctrl_if.sv
// Bus between the calculator core and display_scan_ctrl: load request in,
// scanned digit/anode drive and conversion status out.
interface display_scan_ctrl_if;
  logic [7:0] Value;
  logic       Load;
  logic [3:0] BCD;
  logic [3:0] Anode;
  logic       Busy;
  logic       Done;

  modport master (output Value, Load, input BCD, Anode, Busy, Done);
  modport slave  (input Value, Load, output BCD, Anode, Busy, Done);
endinterface

// File: rtl/display_scan_ctrl.sv
// 8-bit binary to 3-digit BCD (sequential shift-and-add-3) feeding a multiplexed
// common-anode scan. Define LEADING_ZERO_BLANK_EN to darken leading-zero digits.
module display_scan_ctrl #(
  parameter int REFRESH_DIV = 100000
) (
  input logic                clk,
  input logic                rst_n,
  display_scan_ctrl_if.slave bus
);
  localparam int              RC_W    = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(REFRESH_DIV - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t          state, state_nxt;
  logic [7:0]      sr;
  logic [11:0]     acc;
  logic [11:0]     acc_adj;
  logic [11:0]     acc_fin;
  logic [2:0]      iter;
  logic            pend;
  logic [7:0]      pend_val;
  logic [3:0]      hund, tens, ones;
  logic            done_r;
  logic            busy;
  logic            last_iter;
  logic            load_now;
  logic [7:0]      load_src;
  logic [RC_W-1:0] rc;
  logic [1:0]      idx;
  logic [3:0]      dig_sel, an_sel;
  logic [3:0]      bcd_q, anode_q;

  function automatic logic [3:0] add3(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

  assign acc_adj   = {add3(acc[11:8]), add3(acc[7:4]), add3(acc[3:0])};
  assign acc_fin   = {acc_adj[10:0], sr[7]};
  assign last_iter = (state == SHIFT) && (iter == 3'd7);
  // A load arriving on the completion edge is newer than any stored pending value.
  assign load_now  = ((state == IDLE) && bus.Load) || (last_iter && (bus.Load || pend));
  assign load_src  = bus.Load ? bus.Value : pend_val;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.Load) state_nxt = SHIFT;
      SHIFT:   if (last_iter) state_nxt = (bus.Load || pend) ? SHIFT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    if (state == SHIFT) busy = 1'b1;
    busy = busy | done_r;
  end

  always_ff @(posedge clk) begin
    if (load_now) begin
      sr  <= load_src;
      acc <= '0;
    end else if (state == SHIFT) begin
      {acc, sr} <= {acc_adj, sr} << 1;
    end
    if ((state == SHIFT) && bus.Load) pend_val <= bus.Value;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iter   <= '0;
      pend   <= 1'b0;
      hund   <= '0;
      tens   <= '0;
      ones   <= '0;
      done_r <= 1'b0;
    end else begin
      done_r <= last_iter;
      if (load_now)            iter <= '0;
      else if (state == SHIFT) iter <= iter + 3'd1;
      if (last_iter) begin
        {hund, tens, ones} <= acc_fin;
        pend               <= 1'b0;
      end else if ((state == SHIFT) && bus.Load) begin
        pend <= 1'b1;
      end
    end
  end

  always_comb begin
    dig_sel = ones;
    an_sel  = 4'b1111;
    case (idx)
      2'd0:    begin dig_sel = ones; an_sel = 4'b1110; end
      2'd1:    begin dig_sel = tens; an_sel = 4'b1101; end
      2'd2:    begin dig_sel = hund; an_sel = 4'b1011; end
      default: ;
    endcase
`ifdef LEADING_ZERO_BLANK_EN
    if ((idx == 2'd2) && (hund == 4'd0))                     an_sel = 4'b1111;
    if ((idx == 2'd1) && (hund == 4'd0) && (tens == 4'd0))   an_sel = 4'b1111;
`endif
  end

  // Digit and anode are both registered from idx so they switch on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rc      <= '0;
      idx     <= '0;
      bcd_q   <= '0;
      anode_q <= 4'b1111;
    end else begin
      if (rc == RC_LAST) begin
        rc  <= '0;
        idx <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;
      end else begin
        rc <= rc + 1'b1;
      end
      bcd_q   <= dig_sel;
      anode_q <= an_sel;
    end
  end

  assign bus.BCD   = bcd_q;
  assign bus.Anode = anode_q;
  assign bus.Busy  = busy;
  assign bus.Done  = done_r;
endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed and random-load bench for display_scan_ctrl with a short refresh period.
module tb_display_scan_ctrl;
  localparam int DIV = 4;
`ifdef LEADING_ZERO_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  display_scan_ctrl_if bus();
  display_scan_ctrl #(.REFRESH_DIV(DIV)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [2:0] exp_lit(input logic [11:0] d);
    if (!BLANK) return 3'b111;
    return {d[11:8] != 4'd0, (d[11:8] != 4'd0) || (d[7:4] != 4'd0), 1'b1};
  endfunction

  task automatic do_load(input logic [7:0] v);
    @(negedge clk);
    bus.Value = v;
    bus.Load  = 1'b1;
    @(posedge clk); #1;
    bus.Load  = 1'b0;
  endtask

  task automatic wait_done(output bit ok, output bit bad);
    ok = 1'b0; bad = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(posedge clk); #1;
      if (bus.BCD > 4'd9) bad = 1'b1;
      if (!(bus.Anode inside {4'b1111, 4'b1110, 4'b1101, 4'b1011})) bad = 1'b1;
      if (bus.Done) ok = 1'b1;
    end
  endtask

  task automatic collect(output logic [11:0] digs, output logic [2:0] lit, output bit bad);
    digs = '0; lit = '0; bad = 1'b0;
    repeat (3 * DIV + 2) begin
      @(posedge clk); #1;
      if (bus.BCD > 4'd9) bad = 1'b1;
      case (bus.Anode)
        4'b1110: begin lit[0] = 1'b1; digs[3:0]  = bus.BCD; end
        4'b1101: begin lit[1] = 1'b1; digs[7:4]  = bus.BCD; end
        4'b1011: begin lit[2] = 1'b1; digs[11:8] = bus.BCD; end
        4'b1111: ;
        default: bad = 1'b1;
      endcase
    end
  endtask

  task automatic test_reset;
    bus.Value = '0; bus.Load = 1'b0; rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.BCD !== 4'd0) begin failures++; $display("FAIL reset_bcd got=%0d exp=0", bus.BCD); end
    checks++; if (bus.Anode !== 4'b1111) begin failures++; $display("FAIL reset_anode got=%b exp=1111", bus.Anode); end
    checks++; if (bus.Busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.Busy); end
    checks++; if (bus.Done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus.Done); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.Anode !== 4'b1110) begin failures++; $display("FAIL first_anode got=%b exp=1110", bus.Anode); end
    checks++; if (bus.BCD !== 4'd0) begin failures++; $display("FAIL first_bcd got=%0d exp=0", bus.BCD); end
  endtask

  // Continues straight from test_reset: cycle 0 was the first edge after release.
  task automatic test_scan;
    logic [3:0] seq [3];
    logic [3:0] exp_an;
    seq[0] = 4'b1110; seq[1] = 4'b1101; seq[2] = 4'b1011;
    for (int k = 1; k < 3 * DIV * 2; k++) begin
      @(posedge clk); #1;
      exp_an = seq[(k / DIV) % 3];
      checks++; if (bus.Anode !== exp_an) begin failures++; $display("FAIL scan_anode k=%0d got=%b exp=%b", k, bus.Anode, exp_an); end
      checks++; if (bus.BCD !== 4'd0 || bus.Busy !== 1'b0) begin failures++; $display("FAIL scan_idle k=%0d bcd=%0d busy=%b exp bcd=0 busy=0", k, bus.BCD, bus.Busy); end
    end
  endtask

  task automatic test_convert_173;
    logic [11:0] digs; logic [2:0] lit; bit bad;
    do_load(8'd173);
    for (int i = 0; i <= 9; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      checks++; if (bus.Busy !== (i <= 8)) begin failures++; $display("FAIL conv_busy E%0d got=%b exp=%b", i, bus.Busy, (i <= 8)); end
      checks++; if (bus.Done !== (i == 8)) begin failures++; $display("FAIL conv_done E%0d got=%b exp=%b", i, bus.Done, (i == 8)); end
    end
    collect(digs, lit, bad);
    checks++; if (digs !== 12'h173 || lit !== exp_lit(12'h173) || bad) begin failures++; $display("FAIL conv_173 digits=%h lit=%b bad=%b exp digits=173 lit=%b", digs, lit, bad, exp_lit(12'h173)); end
  endtask

  task automatic test_values;
    logic [7:0]  vals [3];
    logic [11:0] exp  [3];
    logic [11:0] digs; logic [2:0] lit; bit bad, ok;
    vals[0] = 8'd255; exp[0] = 12'h255;
    vals[1] = 8'd0;   exp[1] = 12'h000;
    vals[2] = 8'd7;   exp[2] = 12'h007;
    for (int j = 0; j < 3; j++) begin
      do_load(vals[j]);
      wait_done(ok, bad);
      checks++; if (!ok) begin failures++; $display("FAIL val_done v=%0d got=timeout exp=done", vals[j]); end
      collect(digs, lit, bad);
      checks++; if (digs !== exp[j] || lit !== exp_lit(exp[j]) || bad) begin failures++; $display("FAIL val_digits v=%0d digits=%h lit=%b bad=%b exp digits=%h lit=%b", vals[j], digs, lit, bad, exp[j], exp_lit(exp[j])); end
    end
  endtask

  task automatic test_pending;
    do_load(8'd200);
    for (int i = 0; i <= 18; i++) begin
      checks++; if (bus.Busy !== (i <= 16)) begin failures++; $display("FAIL pend_busy E%0d got=%b exp=%b", i, bus.Busy, (i <= 16)); end
      checks++; if (bus.Done !== (i == 8 || i == 16)) begin failures++; $display("FAIL pend_done E%0d got=%b exp=%b", i, bus.Done, (i == 8 || i == 16)); end
      if (i == 8) begin
        checks++; if ({dut.hund, dut.tens, dut.ones} !== 12'h200) begin failures++; $display("FAIL pend_first got=%h exp=200", {dut.hund, dut.tens, dut.ones}); end
      end
      if (i == 16) begin
        checks++; if ({dut.hund, dut.tens, dut.ones} !== 12'h099) begin failures++; $display("FAIL pend_second got=%h exp=099", {dut.hund, dut.tens, dut.ones}); end
      end
      bus.Load  = (i == 2 || i == 4);
      bus.Value = (i == 2) ? 8'd45 : 8'd99;
      @(posedge clk); #1;
    end
    bus.Load = 1'b0;
  endtask

  task automatic test_back_to_back;
    do_load(8'd37);
    for (int i = 0; i <= 17; i++) begin
      checks++; if (bus.Busy !== (i <= 16)) begin failures++; $display("FAIL b2b_busy E%0d got=%b exp=%b", i, bus.Busy, (i <= 16)); end
      checks++; if (bus.Done !== (i == 8 || i == 16)) begin failures++; $display("FAIL b2b_done E%0d got=%b exp=%b", i, bus.Done, (i == 8 || i == 16)); end
      if (i == 8) begin
        checks++; if ({dut.hund, dut.tens, dut.ones} !== 12'h037) begin failures++; $display("FAIL b2b_first got=%h exp=037", {dut.hund, dut.tens, dut.ones}); end
      end
      if (i == 16) begin
        checks++; if ({dut.hund, dut.tens, dut.ones} !== 12'h150) begin failures++; $display("FAIL b2b_second got=%h exp=150", {dut.hund, dut.tens, dut.ones}); end
      end
      bus.Load  = (i == 7);
      bus.Value = 8'd150;
      @(posedge clk); #1;
    end
    bus.Load = 1'b0;
  endtask

  task automatic test_reset_mid;
    logic [11:0] digs; logic [2:0] lit; bit bad; int dones;
    do_load(8'd123);
    repeat (4) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    checks++; if (bus.Busy !== 1'b0 || bus.Done !== 1'b0) begin failures++; $display("FAIL rmid_status busy=%b done=%b exp 0 0", bus.Busy, bus.Done); end
    checks++; if (bus.Anode !== 4'b1111 || bus.BCD !== 4'd0) begin failures++; $display("FAIL rmid_outputs anode=%b bcd=%0d exp 1111 0", bus.Anode, bus.BCD); end
    checks++; if ({dut.hund, dut.tens, dut.ones} !== 12'h000) begin failures++; $display("FAIL rmid_display got=%h exp=000", {dut.hund, dut.tens, dut.ones}); end
    @(negedge clk); rst_n = 1'b1;
    dones = 0;
    repeat (12) begin @(posedge clk); #1; if (bus.Done) dones++; end
    checks++; if (dones !== 0) begin failures++; $display("FAIL rmid_nodone got=%0d exp=0", dones); end
    collect(digs, lit, bad);
    checks++; if (digs !== 12'h000 || lit !== exp_lit(12'h000) || bad) begin failures++; $display("FAIL rmid_digits digits=%h lit=%b exp digits=000 lit=%b", digs, lit, exp_lit(12'h000)); end
  endtask

  task automatic test_random;
    logic [7:0] v; bit ok, bad; int got;
    for (int n = 0; n < 256; n++) begin
      v = 8'($urandom_range(0, 255));
      do_load(v);
      wait_done(ok, bad);
      got = dut.hund * 100 + dut.tens * 10 + dut.ones;
      checks++; if (!ok || bad || got !== int'(v)) begin failures++; $display("FAIL rand n=%0d got=%0d done=%b bad=%b exp=%0d", n, got, ok, bad, v); end
    end
  endtask

  initial begin
    test_reset;
    test_scan;
    test_convert_173;
    test_values;
    test_pending;
    test_back_to_back;
    test_reset_mid;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
